clock_mode_controller: RTL
==========================

// Module: clock_mode_controller
// PURPOSE
//  Mode/time-keeping controller for the 24 h clock. Sits beside Prescaler and consumes its
//  1 kHz and 1/60 Hz pulses. Gates Prescaler via start, keeps HH:MM in BCD, and debounces the
//  MODE and INC buttons. Runs a RUN -> SET_HR -> SET_MIN -> RUN setting sequence and drives the
//  blink flag for the display mux.
// PARAMETERS
//  DEBOUNCE_MS      20   consecutive 1 kHz ticks of stable raw level before a button level is accepted
//  REPEAT_DELAY_MS  500  INC held this long -> first auto-repeat increment
//  REPEAT_RATE_MS   200  period of further auto-repeat increments while INC is held
//  BLINK_MS         250  blink half-period in set modes
// PORTS
//  clk              in   1  system clock, same clock as Prescaler
//  rst_n            in   1  asynchronous, active-low reset
//  tick_1khz        in   1  1-cycle pulse from Prescaler clock_1000Hz
//  tick_min         in   1  1-cycle pulse from Prescaler clock_1_60Hz
//  btn_mode         in   1  raw MODE button, active-high, asynchronous, bouncy
//  btn_inc          in   1  raw INC button, active-high, asynchronous, bouncy
//  prescaler_start  out  1  to Prescaler start; 1 = minute counter runs, 0 = held at 0
//  hours_bcd        out  8  [7:4] tens 0..2, [3:0] units 0..9, value 00..23
//  minutes_bcd      out  8  [7:4] tens 0..5, [3:0] units 0..9, value 00..59
//  mode             out  2  0 RUN, 1 SET_HR, 2 SET_MIN (3 never driven)
//  blink            out  1  1 = show the field being set; 0 = blank it
// BEHAVIOUR
//  Reset (async assert, sync release): hours_bcd=8'h00, minutes_bcd=8'h00, mode=RUN,
//   prescaler_start=0, blink=0. All debounce and repeat state is cleared.
//  Outputs: all registered. prescaler_start=1 from the 1st clk after reset release while mode=RUN.
//   It is 0 in SET_HR/SET_MIN, so the first minute after returning to RUN is a full 60 s.
//  Buttons:
//   - 2-FF synchroniser, then a debounce counter advanced only on tick_1khz.
//   - Debounced level changes after DEBOUNCE_MS consecutive ticks of equal synced level.
//   - Any mismatch clears the counter.
//   - press = 1-clk pulse on the debounced rising edge.
//   - Latency raw edge -> press: 2 clk + DEBOUNCE_MS ticks + 1 clk.
//  Auto-repeat (INC only): while debounced INC=1, extra pulses fire REPEAT_DELAY_MS ticks after
//   press, then every REPEAT_RATE_MS ticks. A release stops it immediately.
//  FSM (one step per mode press, taking effect on the clk after the press pulse):
//   RUN -> SET_HR -> SET_MIN -> RUN.
//   An INC press in RUN is ignored. Repeat state is cleared on every mode change.
//  RUN: tick_min increments the minutes units digit.
//   - 9 -> 0 carries to the tens digit; 59 -> 00 carries to hours.
//   - Hours 23 -> 00 wraps (23:59 + 1 = 00:00).
//  SET_HR: each INC pulse does hours +1, 23 -> 00, no effect on minutes.
//  SET_MIN: each INC pulse does minutes +1, 59 -> 00, no carry into hours.
//  tick_min is ignored in SET_HR/SET_MIN.
//  Simultaneous events:
//   - tick_min with a mode press in RUN: the increment is applied and the mode advances, same clk.
//   - INC pulse with a mode press in a set mode: the INC applies to the current field, then the mode advances.
//  Blink:
//   - 0 in RUN. Forced to 1 on entry to each set mode and the blink counter is cleared.
//   - Toggles every BLINK_MS ticks of tick_1khz.
//  Reset mid-operation: returns to RUN at 00:00 regardless of state; no partial increment is kept.
// STRUCTURE
//  Package clock24_pkg:
//   - mode encoding MODE_RUN=2'd0, MODE_SET_HR=2'd1, MODE_SET_MIN=2'd2.
//   - BCD limits HR_MAX=8'h23, MIN_MAX=8'h59.
//   - Width function for the ms counters.
//  Sub-module button_debounce (sync + debounce + edge + optional auto-repeat, parameter REPEAT_EN):
//   - instantiated twice: MODE with REPEAT_EN=0, INC with REPEAT_EN=1.
//  Top level holds the FSM, the BCD counters and the blink counter.
// TESTING (bench drives tick_1khz every 8 clk to shorten runs; tick_min driven directly)
//  1 Reset, release -> 00:00, mode=0, blink=0.
//    prescaler_start=0 during reset and 1 on the clk after release.
//  2 In SET_HR: 23 INC presses. In SET_MIN: 59 presses. Return to RUN, then 1 tick_min
//    -> minutes 8'h00, hours 8'h00.
//  3 btn_mode pulsed high for 10 ticks (< DEBOUNCE_MS=20) with bounces
//    -> no press, mode stays 0.
//    Held 25 ticks -> mode=1 within 2 clk + 20 ticks + 2 clk.
//  4 Three clean MODE presses -> mode 1, 2, 0. prescaler_start=0 in modes 1 and 2.
//    Ten tick_min pulses during SET_HR -> minutes unchanged.
//  5 SET_HR from 00, INC held 1450 ticks (delay 500, rate 200).
//    -> press + repeats at 500, 700, 900, 1100, 1300 -> hours 8'h06.
//    Release -> no further change.
//  6 rst_n asserted mid SET_MIN at 12:34 -> immediately 00:00, mode=0, blink=0.
//    Blink check in SET_MIN (BLINK_MS=250): toggles at 250 and 500 ticks after entry.

Source files
------------

// File: rtl/clock24_pkg.sv
// Shared encodings and BCD helpers for the 24 h clock controller.
// Imported by the debounce sub-module and the controller top.
package clock24_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam logic [7:0] HR_MAX  = 8'h23;
  localparam logic [7:0] MIN_MAX = 8'h59;

  // Bits needed to hold 0..n-1
  function automatic int ms_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // {wrap, next}: BCD +1 with wrap to 00 at max
  function automatic logic [8:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    logic [8:0] r;
    if (v == max)
      r = 9'h100;
    else if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button synchroniser, tick-based debouncer, press edge
// detector and optional auto-repeat pulse generator.
module button_debounce
  import clock24_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  input  logic clr,
  output logic pulse
);

  localparam int DW = ms_w(DEBOUNCE_MS);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_d;
  logic          rpt_fire;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
      db_cnt  <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
      pulse   <= (level & ~level_d) | rpt_fire;
      if (tick) begin
        if (s2 == level)
          db_cnt <= '0;
        else if (db_cnt == DW'(DEBOUNCE_MS - 1)) begin
          level  <= s2;
          db_cnt <= '0;
        end else
          db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  generate
    if (REPEAT_EN) begin : g_rpt
      localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS)
                          ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
      localparam int RW = ms_w(RMAX);

      logic [RW-1:0] r_cnt;
      logic [RW-1:0] r_lim;
      logic          r_phase;

      // First repeat waits the long delay, later ones the rate
      assign r_lim = r_phase ? RW'(REPEAT_RATE_MS - 1)
                             : RW'(REPEAT_DELAY_MS - 1);
      assign rpt_fire = level & ~clr & tick & (r_cnt == r_lim);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_phase <= 1'b0;
        end else if (!level || clr) begin
          r_cnt   <= '0;
          r_phase <= 1'b0;
        end else if (tick) begin
          if (r_cnt == r_lim) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
          end else
            r_cnt <= r_cnt + RW'(1);
        end
      end
    end else begin : g_no_rpt
      logic unused_clr;
      assign unused_clr = clr;
      assign rpt_fire   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/clock_mode_controller.sv
// 24 h clock mode FSM, BCD time counters, set-mode blink
// and prescaler gating.
module clock_mode_controller
  import clock24_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 200,
  parameter int BLINK_MS        = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1khz,
  input  logic       tick_min,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       prescaler_start,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int BW = ms_w(BLINK_MS);

  mode_e         mode_q;
  mode_e         mode_n;
  logic          mode_press;
  logic          inc_press;
  logic          mode_chg;
  logic [8:0]    hr_inc;
  logic [8:0]    min_inc;
  logic [7:0]    hr_n;
  logic [7:0]    min_n;
  logic          blink_n;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_n;

  button_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .REPEAT_EN   (1'b0)
  ) u_mode_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_1khz),
    .raw   (btn_mode),
    .clr   (1'b0),
    .pulse (mode_press)
  );

  button_debounce #(
    .DEBOUNCE_MS     (DEBOUNCE_MS),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
    .REPEAT_RATE_MS  (REPEAT_RATE_MS)
  ) u_inc_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_1khz),
    .raw   (btn_inc),
    .clr   (mode_chg),
    .pulse (inc_press)
  );

  assign mode_chg = (mode_n != mode_q);
  assign hr_inc   = bcd_inc(hours_bcd, HR_MAX);
  assign min_inc  = bcd_inc(minutes_bcd, MIN_MAX);
  assign mode     = mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mode_q <= MODE_RUN;
    else
      mode_q <= mode_n;
  end

  always_comb begin
    mode_n = mode_q;
    if (mode_press) begin
      unique case (mode_q)
        MODE_RUN:    mode_n = MODE_SET_HR;
        MODE_SET_HR: mode_n = MODE_SET_MIN;
        default:     mode_n = MODE_RUN;
      endcase
    end
  end

  // Increments use the current mode, so a coincident mode press
  // never swallows them
  always_comb begin
    hr_n  = hours_bcd;
    min_n = minutes_bcd;
    unique case (1'b1)
      (mode_q == MODE_RUN) && tick_min: begin
        min_n = min_inc[7:0];
        if (min_inc[8])
          hr_n = hr_inc[7:0];
      end
      (mode_q == MODE_SET_HR) && inc_press:
        hr_n = hr_inc[7:0];
      (mode_q == MODE_SET_MIN) && inc_press:
        min_n = min_inc[7:0];
      default: ;
    endcase
  end

  always_comb begin
    blink_n     = blink;
    blink_cnt_n = blink_cnt;
    if (mode_n == MODE_RUN) begin
      blink_n     = 1'b0;
      blink_cnt_n = '0;
    end else if (mode_chg) begin
      blink_n     = 1'b1;
      blink_cnt_n = '0;
    end else if (tick_1khz) begin
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_n     = ~blink;
        blink_cnt_n = '0;
      end else
        blink_cnt_n = blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours_bcd       <= 8'h00;
      minutes_bcd     <= 8'h00;
      blink           <= 1'b0;
      blink_cnt       <= '0;
      prescaler_start <= 1'b0;
    end else begin
      hours_bcd       <= hr_n;
      minutes_bcd     <= min_n;
      blink           <= blink_n;
      blink_cnt       <= blink_cnt_n;
      prescaler_start <= (mode_n == MODE_RUN);
    end
  end

endmodule
